alu_cmd_issue: RTL and testbench
================================

Name: alu_cmd_issue

Overview:
- Multi-cycle command sequencer wrapped around the combinational shift+ALU stage.
- Accepts an operation command over a valid/ready handshake and registers the operands onto the ALU stage inputs.
- Waits a fixed settle latency, then captures the ALU result and flags into an output register offered over a second valid/ready handshake.
- Also keeps an operation counter and sticky overflow/carry status for the control unit.

Parameters:
- WIDTH, 5, datapath width of operands and result.
- LAT, 1, cycles from operand launch to result capture (legal range 1..15).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_a  input  WIDTH  operand A (pre-shift).
- cmd_b  input  WIDTH  operand B.
- cmd_alucontrol  input  3  ALU operation code.
- cmd_bshift  input  2  shift amount applied to A.
- cmd_select  input  1  0 = left shift, 1 = right shift.
- alu_a  output  WIDTH  registered operand A to the ALU stage.
- alu_b  output  WIDTH  registered operand B to the ALU stage.
- alu_control  output  3  registered op code to the ALU stage.
- alu_bshift  output  2  registered shift amount to the ALU stage.
- alu_select  output  1  registered shift direction to the ALU stage.
- alu_result  input  WIDTH  result from the ALU stage.
- alu_flags  input  4  flags from the ALU stage, {N,Z,C,V}.
- res_valid  output  1  captured result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  captured result.
- res_flags  output  4  captured {N,Z,C,V}.
- sticky_cv  output  2  {C,V} OR-accumulated since the last clear.
- sticky_clr  input  1  synchronous clear of sticky_cv.
- op_count  output  CNT_W  count of completed result handshakes, wraps.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset state: state = IDLE; all alu_* outputs = 0; res_data = 0; res_flags = 0; res_valid = 0; sticky_cv = 0; op_count = 0. cmd_ready goes to 1 once the block is in IDLE.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch all cmd_* fields into the alu_* registers, load wait counter with LAT-1, go to EXEC.
- EXEC:
  - cmd_ready = 0.
  - Wait counter decrements each cycle.
  - In the cycle the counter equals 0: capture alu_result -> res_data and alu_flags -> res_flags, OR {alu_flags[1], alu_flags[0]} into sticky_cv, go to DONE.
  - Net latency: first res_valid cycle = acceptance edge + LAT + 1 cycles.
- DONE:
  - res_valid = 1; res_data and res_flags are held stable.
  - On res_ready: op_count increments (modulo 2^CNT_W), go to IDLE.
  - res_ready low holds DONE indefinitely, with no loss of data.
- Operand stability: alu_* outputs change only on command acceptance and stay constant through EXEC and DONE, so the combinational stage output is stable at capture.
- cmd_ready is asserted only in IDLE, so there is no combinational path from res_ready to cmd_ready. Throughput is 1 op per LAT+2 cycles minimum.
- sticky_clr:
  - Clears sticky_cv at the next edge.
  - If it coincides with a capture edge, the clear wins, then the new {C,V} is ORed in, so sticky_cv reflects the current op only.
- Reset mid-operation (EXEC or DONE): the pending command and result are discarded and all state returns to reset values immediately.
- res_valid and cmd_ready are never both 1.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2.
  - Flag bit indices: N = 3, Z = 2, C = 1, V = 0.
  - Shift-direction constants: SH_LEFT = 0, SH_RIGHT = 1.
- One natural sub-module, alu_flag_acc: sticky {C,V} register with the clear/OR priority rule above.
- The FSM, wait counter and op counter stay in alu_cmd_issue.

Test Plan:
- Basic add with defaults (WIDTH=5, LAT=1), stage instantiated:
  - Stimulus: a=3, b=4, bshift=0, select=0, alucontrol=000 (ADD), res_ready held 1.
  - Response: res_valid for exactly 1 cycle, 2 cycles after acceptance; res_data=7, res_flags=0000; op_count=1.
- Left shift then add:
  - Stimulus: a=5'b00011, bshift=2, select=0, b=1, ADD.
  - Response: res_data=13, flags=0000.
- Signed overflow:
  - Stimulus: a=15, bshift=0, b=1, ADD.
  - Response: res_data=16, res_flags=1001; sticky_cv=01 and it stays 01 after a following 3+4 op.
  - Follow-up: pulse sticky_clr -> sticky_cv=00.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles after res_valid rises, cmd_valid held 1 with new operands.
  - Response: res_data/res_flags stable and cmd_ready=0 throughout; after res_ready=1, one cycle later cmd_ready=1 and the second command is accepted.
- Reset mid-EXEC:
  - Stimulus: LAT=4; deassert rst_n 2 cycles after acceptance.
  - Response: all outputs 0 asynchronously; after release, cmd_ready=1 and no res_valid appears for the aborted command.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 back-to-back ops.
  - Response: op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_cmd_issue_pkg.sv
// Shared definitions for the ALU command sequencer slice.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
// Contents: FSM state encoding, {N,Z,C,V} flag bit indices, shift-direction codes.
package alu_cmd_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

  // Extract the {C,V} pair that feeds the sticky status.
  function automatic logic [1:0] flags_cv(input logic [3:0] flags);
    return {flags[FLAG_C], flags[FLAG_V]};
  endfunction

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Bundles the command handshake, the ALU-stage operand/result wires and the result handshake.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready and res_valid/res_ready, both standard valid/ready.
// Modports: slave = the sequencer's view, master = the environment (producer, ALU stage, consumer).
interface alu_cmd_issue_if #(
  parameter int WIDTH = 5
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_alucontrol;
  logic [1:0]       cmd_bshift;
  logic             cmd_select;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [1:0]       alu_bshift;
  logic             alu_select;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_alucontrol, cmd_bshift, cmd_select,
    output cmd_ready,
    output alu_a, alu_b, alu_control, alu_bshift, alu_select,
    input  alu_result, alu_flags,
    output res_valid, res_data, res_flags,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_alucontrol, cmd_bshift, cmd_select,
    input  cmd_ready,
    input  alu_a, alu_b, alu_control, alu_bshift, alu_select,
    output alu_result, alu_flags,
    input  res_valid, res_data, res_flags,
    output res_ready
  );

endinterface

// File: rtl/alu_flag_acc.sv
// Sticky {C,V} status: OR-accumulates the carry/overflow of every captured result.
// Latency: updates on the edge after clr/set_en.
// Backpressure: none; a clear coinciding with a capture wipes history first, then ORs the new pair.
// Ports: clk, rst_n, clr (sync clear), set_en (capture strobe), cv_in (new {C,V}), cv (sticky out).
module alu_flag_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       set_en,
  input  logic [1:0] cv_in,
  output logic [1:0] cv
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv <= 2'b00;
    end else if (clr || set_en) begin
      // Clear has priority over history but not over the op captured on the same edge.
      cv <= (clr ? 2'b00 : cv) | (set_en ? cv_in : 2'b00);
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Multi-cycle sequencer around a combinational shift+ALU stage: launch operands, wait, capture.
// Latency: result valid LAT+1 cycles after the accepting cycle; one op per LAT+2 cycles at best.
// Backpressure: cmd_ready only in IDLE; res_ready low holds the result in DONE indefinitely.
// Ports: clk, rst_n, bus (command / ALU stage / result handshakes), sticky_clr, sticky_cv, op_count.
module alu_cmd_issue
  import alu_cmd_issue_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issue_if.slave   bus,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_cv,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q;
  state_e           state_d;
  logic [3:0]       wait_q;
  logic             load;
  logic             capture;
  logic             res_hs;
  logic             cmd_ready_c;
  logic             res_valid_c;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctl_q;
  logic [1:0]       sh_q;
  logic             sel_q;
  logic [WIDTH-1:0] data_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    capture     = 1'b0;
    res_hs      = 1'b0;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Operands have been stable for LAT cycles once the counter hits zero.
        if (wait_q == 4'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          res_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
    end else if (load) begin
      wait_q <= 4'(LAT - 1);
    end else if (state_q == EXEC && wait_q != 4'd0) begin
      wait_q <= wait_q - 4'd1;
    end
  end

  // Operand registers move only on acceptance, so the ALU stage is quiet through EXEC/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      ctl_q <= 3'd0;
      sh_q  <= 2'd0;
      sel_q <= 1'b0;
    end else if (load) begin
      a_q   <= bus.cmd_a;
      b_q   <= bus.cmd_b;
      ctl_q <= bus.cmd_alucontrol;
      sh_q  <= bus.cmd_bshift;
      sel_q <= bus.cmd_select;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      flags_q <= 4'd0;
    end else if (capture) begin
      data_q  <= bus.alu_result;
      flags_q <= bus.alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (res_hs) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  alu_flag_acc u_flag_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sticky_clr),
    .set_en (capture),
    .cv_in  (flags_cv(bus.alu_flags)),
    .cv     (sticky_cv)
  );

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.res_data    = data_q;
  assign bus.res_flags   = flags_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = ctl_q;
  assign bus.alu_bshift  = sh_q;
  assign bus.alu_select  = sel_q;
  assign op_count        = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: behavioural shift+ALU stage, scoreboard queue filled at issue,
// independent monitor comparing results, latency, sticky status and op counter every cycle.
module tb_alu_cmd_issue;
  import alu_cmd_issue_pkg::*;

  localparam int W     = 5;
  localparam int LAT_P = 3;
  localparam int CNT_P = 2;

  logic             clk;
  logic             rst_n;
  logic             sticky_clr;
  logic [1:0]       sticky_cv;
  logic [CNT_P-1:0] op_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit rnd_mode = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   flags;
    int           edge_no;
  } exp_t;

  exp_t sb[$];

  alu_cmd_issue_if #(.WIDTH(W)) bus ();

  alu_cmd_issue #(.WIDTH(W), .LAT(LAT_P), .CNT_W(CNT_P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sticky_clr (sticky_clr),
    .sticky_cv  (sticky_cv),
    .op_count   (op_count)
  );

  // Reference shift+ALU: returns {N,Z,C,V,result}.
  function automatic logic [W+3:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op, input logic [1:0] sh,
                                          input logic sel);
    logic [W-1:0] sa, r;
    logic c, v;
    int s;
    sa = (sel == SH_LEFT) ? (a << sh) : (a >> sh);
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = int'(sa) + int'(b);
        r = W'(s);
        c = (s >= (1 << W));
        v = (sa[W-1] == b[W-1]) && (r[W-1] != sa[W-1]);
      end
      3'd1: begin
        s = int'(sa) - int'(b);
        r = W'(s);
        c = (sa >= b);
        v = (sa[W-1] != b[W-1]) && (r[W-1] != sa[W-1]);
      end
      3'd2: r = sa & b;
      3'd3: r = sa | b;
      3'd4: r = sa ^ b;
      default: r = sa;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  assign {bus.alu_flags, bus.alu_result} =
    ref_op(bus.alu_a, bus.alu_b, bus.alu_control, bus.alu_bshift, bus.alu_select);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge; in random mode also jitter res_ready and sticky_clr.
  task automatic tick();
    @(negedge clk);
    if (rnd_mode) begin
      bus.res_ready = ($urandom_range(0, 3) != 0);
      sticky_clr    = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [1:0] sh, input logic sel);
    int waited = 0;
    exp_t e;
    bus.cmd_valid      = 1'b1;
    bus.cmd_a          = a;
    bus.cmd_b          = b;
    bus.cmd_alucontrol = op;
    bus.cmd_bshift     = sh;
    bus.cmd_select     = sel;
    while (!bus.cmd_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    {e.flags, e.data} = ref_op(a, b, op, sh, sel);
    e.edge_no = cyc + 1;
    sb.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !bus.cmd_ready) && n < 500) begin
      tick();
      n++;
    end
    check("drain_idle", (sb.size() == 0) && bus.cmd_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_alu_a"},     bus.alu_a, 0);
    check({tag, "_alu_b"},     bus.alu_b, 0);
    check({tag, "_alu_ctl"},   bus.alu_control, 0);
    check({tag, "_alu_sh"},    bus.alu_bshift, 0);
    check({tag, "_alu_sel"},   bus.alu_select, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"},  bus.res_data, 0);
    check({tag, "_res_flags"}, bus.res_flags, 0);
    check({tag, "_sticky"},    sticky_cv, 0);
    check({tag, "_op_count"},  op_count, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  // Monitor: per-cycle model of result handshake, sticky status and wrap-around counter.
  initial begin : monitor
    logic         prev_vld;
    logic         hs;
    logic [W-1:0] held_d;
    logic [3:0]   held_f;
    logic [1:0]   m_st;
    int           m_cnt;
    exp_t         e;
    prev_vld = 1'b0;
    held_d   = '0;
    held_f   = '0;
    m_st     = 2'b00;
    m_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_vld = 1'b0;
        m_st     = 2'b00;
        m_cnt    = 0;
      end else begin
        hs = prev_vld && bus.res_ready;
        if (hs) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_P);
          check("res_valid_drop", bus.res_valid, 0);
        end
        if (sticky_clr) m_st = 2'b00;
        if (bus.res_valid && !prev_vld) begin
          if (sb.size() == 0) begin
            check("res_valid_unexpected", bus.res_valid, 0);
          end else begin
            e = sb.pop_front();
            check("res_data",    bus.res_data, e.data);
            check("res_flags",   bus.res_flags, e.flags);
            check("res_latency", cyc, e.edge_no + LAT_P);
            m_st   = m_st | e.flags[1:0];
            held_d = e.data;
            held_f = e.flags;
          end
        end else if (bus.res_valid) begin
          check("res_data_hold",  bus.res_data, held_d);
          check("res_flags_hold", bus.res_flags, held_f);
        end else if (prev_vld && !hs) begin
          check("res_valid_hold", bus.res_valid, 1);
        end
        check("sticky_cv", sticky_cv, m_st);
        check("op_count", op_count, m_cnt);
        check("valid_ready_excl", bus.res_valid && bus.cmd_ready, 0);
        prev_vld = bus.res_valid;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n              = 1'b0;
    sticky_clr         = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_a          = '0;
    bus.cmd_b          = '0;
    bus.cmd_alucontrol = 3'd0;
    bus.cmd_bshift     = 2'd0;
    bus.cmd_select     = 1'b0;
    bus.res_ready      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    tick();

    // Directed: plain add, shifted add, signed overflow, sticky persistence, then clear.
    send(5'd3,  5'd4, 3'd0, 2'd0, SH_LEFT);
    send(5'd3,  5'd1, 3'd0, 2'd2, SH_LEFT);
    send(5'd15, 5'd1, 3'd0, 2'd0, SH_LEFT);
    send(5'd3,  5'd4, 3'd0, 2'd0, SH_LEFT);
    wait_idle();
    check("sticky_kept", sticky_cv, 2'b01);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tick();
    check("sticky_cleared", sticky_cv, 2'b00);

    // Backpressure: result held while a new command waits.
    bus.res_ready = 1'b0;
    send(5'd22, 5'd9, 3'd1, 2'd1, SH_RIGHT);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid_rise", bus.res_valid, 1);
    bus.cmd_valid      = 1'b1;
    bus.cmd_a          = 5'd2;
    bus.cmd_b          = 5'd5;
    bus.cmd_alucontrol = 3'd0;
    bus.cmd_bshift     = 2'd0;
    bus.cmd_select     = SH_LEFT;
    repeat (10) begin
      tick();
      check("bp_cmd_ready_low", bus.cmd_ready, 0);
    end
    bus.res_ready = 1'b1;
    tick();
    check("bp_cmd_ready_back", bus.cmd_ready, 1);
    send(5'd2, 5'd5, 3'd0, 2'd0, SH_LEFT);
    wait_idle();

    // Random traffic with random backpressure and sticky clears.
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(W'($urandom), W'($urandom), 3'($urandom_range(0, 5)),
           2'($urandom), 1'($urandom));
    end
    rnd_mode      = 1'b0;
    sticky_clr    = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle();

    // Reset two cycles into EXEC: everything returns to reset values, no result appears.
    send(5'd15, 5'd1, 3'd0, 2'd0, SH_LEFT);
    send(5'd6,  5'd3, 3'd0, 2'd0, SH_LEFT);
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_vals("mid_rst");
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("no_res_after_abort", bus.res_valid, 0);
    check("ready_after_abort", bus.cmd_ready, 1);

    // Back-to-back ops after reset, walking the counter through a wrap.
    for (int i = 0; i < 5; i++) begin
      send(W'($urandom), W'($urandom), 3'($urandom_range(0, 4)), 2'($urandom), 1'($urandom));
    end
    wait_idle();
    check("sb_empty_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
